// File: rtl/blob_centroid_tracker.sv
// Colour-threshold blob tracker: accumulates matching-pixel row/col sums per frame, then
// finds the centroid with a 32-step restoring divider. Optional macro: CENTROID_SMOOTH_EN.
module blob_centroid_tracker #(
    parameter int          H_ACTIVE   = 800,
    parameter int          V_ACTIVE   = 600,
    parameter logic [7:0]  R_MIN      = 8'd160,
    parameter logic [7:0]  G_MAX      = 8'd80,
    parameter logic [7:0]  B_MAX      = 8'd80,
    parameter logic [19:0] MIN_PIXELS = 20'd64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic [31:0] i_data,
    output logic [9:0]  o_row,
    output logic [9:0]  o_col,
    output logic        o_found,
    output logic        o_update,
    output logic        o_overrun
);
    typedef enum logic [2:0] {IDLE, DIV_ROW, DIV_COL, DONE, MISS} state_t;

    state_t      state_reg, state_next;
    logic [9:0]  row_reg, col_reg;
    logic [31:0] sum_row_reg, sum_col_reg;
    logic [19:0] cnt_reg;
    logic [31:0] snap_sum_col_reg;
    logic [19:0] snap_cnt_reg;
    logic [31:0] dq_reg, rem_reg;
    logic [4:0]  iter_reg;
    logic [9:0]  quot_row_reg;
    logic [9:0]  row_out_reg, col_out_reg;
    logic        found_reg, update_reg, overrun_reg;

    logic        match, last_col, last_row, eof;
    logic [31:0] fin_sum_row, fin_sum_col;
    logic [19:0] fin_cnt;
    logic [31:0] divisor, trial, rem_step, dq_step;
    logic        fits, last_iter;
    logic [9:0]  row_new, col_new;
    logic        unused_bits;

    assign match    = i_valid && (i_data[23:16] >= R_MIN) && (i_data[15:8] <= G_MAX)
                      && (i_data[7:0] <= B_MAX);
    assign last_col = (col_reg == 10'(H_ACTIVE - 1));
    assign last_row = (row_reg == 10'(V_ACTIVE - 1));
    assign eof      = i_valid && last_col && last_row;

    // Totals including the current pixel, so the EOF pixel lands in the snapshot.
    assign fin_sum_row = sum_row_reg + (match ? {22'b0, row_reg} : 32'd0);
    assign fin_sum_col = sum_col_reg + (match ? {22'b0, col_reg} : 32'd0);
    assign fin_cnt     = cnt_reg + {19'b0, match};

    // One restoring step: dq_reg shifts the dividend out of its MSB and the quotient into its LSB.
    assign divisor   = {12'b0, snap_cnt_reg};
    assign trial     = {rem_reg[30:0], dq_reg[31]};
    assign fits      = (trial >= divisor);
    assign rem_step  = fits ? (trial - divisor) : trial;
    assign dq_step   = {dq_reg[30:0], fits};
    assign last_iter = (iter_reg == 5'd31);

`ifdef CENTROID_SMOOTH_EN
    logic [10:0] row_sum, col_sum;
    assign row_sum = {1'b0, row_out_reg} + {1'b0, quot_row_reg};
    assign col_sum = {1'b0, col_out_reg} + {1'b0, dq_reg[9:0]};
    // Averaging only chains from a previous found frame; after reset or a miss the raw value loads.
    assign row_new = found_reg ? 10'(row_sum >> 1) : quot_row_reg;
    assign col_new = found_reg ? 10'(col_sum >> 1) : dq_reg[9:0];
`else
    assign row_new = quot_row_reg;
    assign col_new = dq_reg[9:0];
`endif

    assign unused_bits = ^{i_data[31:24], rem_reg[31]};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (eof) state_next = (fin_cnt >= MIN_PIXELS) ? DIV_ROW : MISS;
            DIV_ROW: if (last_iter) state_next = DIV_COL;
            DIV_COL: if (last_iter) state_next = DONE;
            DONE:    state_next = IDLE;
            MISS:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            row_reg          <= '0;
            col_reg          <= '0;
            sum_row_reg      <= '0;
            sum_col_reg      <= '0;
            cnt_reg          <= '0;
            snap_sum_col_reg <= '0;
            snap_cnt_reg     <= '0;
            dq_reg           <= '0;
            rem_reg          <= '0;
            iter_reg         <= '0;
            quot_row_reg     <= '0;
            row_out_reg      <= 10'(V_ACTIVE / 2);
            col_out_reg      <= 10'(H_ACTIVE / 2);
            found_reg        <= 1'b0;
            update_reg       <= 1'b0;
            overrun_reg      <= 1'b0;
        end else begin
            if (i_valid) begin
                if (last_col) begin
                    col_reg <= '0;
                    row_reg <= last_row ? 10'd0 : row_reg + 10'd1;
                end else begin
                    col_reg <= col_reg + 10'd1;
                end
            end

            if (eof) begin
                sum_row_reg <= '0;
                sum_col_reg <= '0;
                cnt_reg     <= '0;
            end else if (match) begin
                sum_row_reg <= fin_sum_row;
                sum_col_reg <= fin_sum_col;
                cnt_reg     <= fin_cnt;
            end

            overrun_reg <= eof && (state_reg != IDLE);
            update_reg  <= 1'b0;

            case (state_reg)
                IDLE: if (eof) begin
                    snap_sum_col_reg <= fin_sum_col;
                    snap_cnt_reg     <= fin_cnt;
                    dq_reg           <= fin_sum_row;
                    rem_reg          <= '0;
                    iter_reg         <= '0;
                end
                DIV_ROW: begin
                    iter_reg <= iter_reg + 5'd1;
                    if (last_iter) begin
                        quot_row_reg <= dq_step[9:0];
                        dq_reg       <= snap_sum_col_reg;
                        rem_reg      <= '0;
                    end else begin
                        dq_reg  <= dq_step;
                        rem_reg <= rem_step;
                    end
                end
                DIV_COL: begin
                    iter_reg <= iter_reg + 5'd1;
                    dq_reg   <= dq_step;
                    rem_reg  <= rem_step;
                end
                DONE: begin
                    row_out_reg <= row_new;
                    col_out_reg <= col_new;
                    found_reg   <= 1'b1;
                    update_reg  <= 1'b1;
                end
                MISS: begin
                    found_reg  <= 1'b0;
                    update_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_row     = row_out_reg;
    assign o_col     = col_out_reg;
    assign o_found   = found_reg;
    assign o_update  = update_reg;
    assign o_overrun = overrun_reg;
endmodule

// File: tb/tb_blob_centroid_tracker.sv
// Directed bench: a 16x12 tracker for centroid/miss/reset cases and a 2x2 tracker for overrun.
module tb_blob_centroid_tracker;
    localparam int H = 16;
    localparam int V = 12;
    localparam logic [31:0] RED = 32'h00FF0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [31:0] data;
    logic [9:0]  row, col;
    logic        found, upd, ovr;
    logic        s_valid;
    logic [31:0] s_data;
    logic [9:0]  s_row, s_col;
    logic        s_found, s_upd, s_ovr;

    always #5 clk = ~clk;

    blob_centroid_tracker #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_PIXELS(20'd4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data),
        .o_row(row), .o_col(col), .o_found(found), .o_update(upd), .o_overrun(ovr)
    );

    blob_centroid_tracker #(.H_ACTIVE(2), .V_ACTIVE(2), .MIN_PIXELS(20'd1)) dut_small (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(s_valid), .i_data(s_data),
        .o_row(s_row), .o_col(s_col), .o_found(s_found), .o_update(s_upd), .o_overrun(s_ovr)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] img [V][H];
    logic [9:0]  exp_row, exp_col;
    logic        exp_found;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s got=%0d", tag, got);
        end
    endtask

    // Expected output after a found frame, given the previous output and found flag.
    function automatic logic [9:0] expv(input logic [9:0] old, input logic [9:0] q, input logic was_found);
`ifdef CENTROID_SMOOTH_EN
        if (was_found) return 10'((int'(old) + int'(q)) >> 1);
        return q;
`else
        return q;
`endif
    endfunction

    task automatic clear_img();
        for (int r = 0; r < V; r++)
            for (int c = 0; c < H; c++)
                img[r][c] = 32'h0;
    endtask

    task automatic put_blob(input int r0, input int c0);
        img[r0][c0] = RED; img[r0][c0+1] = RED;
        img[r0+1][c0] = RED; img[r0+1][c0+1] = RED;
    endtask

    task automatic send_frame(input int gap_max);
        for (int r = 0; r < V; r++) begin
            for (int c = 0; c < H; c++) begin
                if (gap_max > 0) begin
                    repeat ($urandom_range(0, gap_max)) begin
                        valid = 1'b0;
                        @(posedge clk); #1;
                    end
                end
                valid = 1'b1;
                data  = img[r][c];
                @(posedge clk); #1;
            end
        end
        valid = 1'b0;
        data  = 32'h0;
    endtask

    task automatic wait_update(input string tag, input int exp_lat);
        int n = 0;
        while (!upd && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, n, exp_lat);
    endtask

    task automatic check_result(input string tag, input logic [9:0] q_row, input logic [9:0] q_col,
                                input logic is_found);
        if (is_found) begin
            exp_row = expv(exp_row, q_row, exp_found);
            exp_col = expv(exp_col, q_col, exp_found);
        end
        exp_found = is_found;
        check({tag, "_row"}, row, exp_row);
        check({tag, "_col"}, col, exp_col);
        check({tag, "_found"}, found, exp_found);
        @(posedge clk); #1;
        check({tag, "_upd_one_cycle"}, upd, 0);
    endtask

    task automatic send_small(input logic [3:0] red_mask);
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data  = red_mask[i] ? RED : 32'h0;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_data  = 32'h0;
    endtask

    initial begin
        int n;
        int extra;
        rst_n = 1'b0; valid = 1'b0; data = 32'h0; s_valid = 1'b0; s_data = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state and idle with no pixels.
        exp_row = 10'd6; exp_col = 10'd8; exp_found = 1'b0;
        check("reset_row", row, 6);
        check("reset_col", col, 8);
        check("reset_found", found, 0);
        check("reset_ovr", ovr, 0);
        extra = 0;
        repeat (20) begin @(posedge clk); #1; if (upd) extra++; end
        check("idle_no_update", extra, 0);

        // 2x2 blob with one exact-threshold pixel plus near-miss colours elsewhere.
        clear_img();
        put_blob(4, 10);
        img[4][10] = 32'h00A05050;
        img[0][0]  = 32'h009F0000;
        img[0][1]  = 32'h00A05100;
        img[0][2]  = 32'h00A00051;
        img[7][3]  = 32'h00FF5151;
        send_frame(0);
        wait_update("blob", 65);
        check_result("blob", 10'd4, 10'd10, 1'b1);

        // Three matches: below MIN_PIXELS.
        clear_img();
        img[0][0] = RED; img[0][1] = RED; img[1][0] = RED;
        send_frame(0);
        wait_update("miss", 1);
        check_result("miss", 10'd0, 10'd0, 1'b0);

        // Blob again with random input gaps.
        clear_img();
        put_blob(4, 10);
        send_frame(3);
        wait_update("gaps", 65);
        check_result("gaps", 10'd4, 10'd10, 1'b1);

        // Matching EOF pixel counted in the snapshot: (11,15),(0,0),(0,1),(1,0) -> (3,4).
        clear_img();
        img[11][15] = RED; img[0][0] = RED; img[0][1] = RED; img[1][0] = RED;
        send_frame(2);
        wait_update("eofpix", 65);
        check_result("eofpix", 10'd3, 10'd4, 1'b1);

        // Miss, then blobs at (4,10) and (8,14): smoothing chain restarts after the miss.
        clear_img();
        img[0][0] = RED;
        send_frame(0);
        wait_update("miss2", 1);
        check_result("miss2", 10'd0, 10'd0, 1'b0);
        clear_img();
        put_blob(4, 10);
        send_frame(0);
        wait_update("chainA", 65);
        check_result("chainA", 10'd4, 10'd10, 1'b1);
        clear_img();
        put_blob(8, 14);
        send_frame(0);
        wait_update("chainB", 65);
        check_result("chainB", 10'd8, 10'd14, 1'b1);

        // Reset during division abandons the result.
        clear_img();
        put_blob(2, 2);
        send_frame(0);
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_row", row, 6);
        check("midrst_col", col, 8);
        check("midrst_found", found, 0);
        check("midrst_upd", upd, 0);
        extra = 0;
        repeat (80) begin @(posedge clk); #1; if (upd) extra++; end
        check("midrst_no_update", extra, 0);

        // Overrun on the 2x2 geometry: second EOF lands while dividing the first frame.
        check("small_reset_row", s_row, 1);
        check("small_reset_col", s_col, 1);
        send_small(4'b1111);
        send_small(4'b1000);
        check("ovr_pulse", s_ovr, 1);
        n = 0;
        @(posedge clk); #1;
        n++;
        check("ovr_one_cycle", s_ovr, 0);
        while (!s_upd && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("ovr_first_latency", n, 61);
        check("ovr_first_row", s_row, 0);
        check("ovr_first_col", s_col, 0);
        check("ovr_first_found", s_found, 1);
        extra = 0;
        repeat (80) begin @(posedge clk); #1; if (s_upd) extra++; end
        check("ovr_discarded", extra, 0);
        check("ovr_row_kept", s_row, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
